// File: rtl/sd_asset_loader.sv
// Asset loader: walks a descriptor table and sequences SD sector reads,
// with a per-sector watchdog, bounded retries and request preemption.
module sd_asset_loader #(
    parameter int ASSET_NUM = 64,
    parameter int ID_W      = 6,
    parameter int LEN_W     = 11,
    parameter int TMO_W     = 20,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [ID_W-1:0]  cfg_idx,
    input  logic [31:0]      cfg_base,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             req_valid,
    input  logic [ID_W-1:0]  req_id,
    output logic             req_ready,
    input  logic             rd_busy,
    output logic             rd_start_en,
    output logic [31:0]      rd_sec_addr,
    output logic [ID_W-1:0]  ld_id,
    output logic [LEN_W-1:0] ld_sec_idx,
    output logic             ld_active,
    output logic             ld_done,
    output logic             ld_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    localparam logic [ID_W:0] ID_LIM = (ID_W + 1)'(ASSET_NUM);

    logic [31:0]      tbl_base [ASSET_NUM];
    logic [LEN_W-1:0] tbl_len  [ASSET_NUM];

    logic [2:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [TMO_W-1:0] tmo;
    logic [RTY_W-1:0] retry;
    logic             busy_d0;
    logic             busy_d1;

    logic             cfg_ok;
    logic             id_ok;
    logic             accept;
    logic             cpl;
    logic [31:0]      sel_base;
    logic [LEN_W-1:0] sel_len;
    logic             empty_ld;

    assign cfg_ok   = {1'b0, cfg_idx} < ID_LIM;
    assign id_ok    = {1'b0, req_id} < ID_LIM;
    assign sel_base = id_ok ? tbl_base[req_id] : 32'd0;
    assign sel_len  = id_ok ? tbl_len[req_id] : '0;
    assign empty_ld = !id_ok || (sel_len == '0);
    assign accept   = req_valid && req_ready;
    assign cpl      = busy_d1 & ~busy_d0;

    assign req_ready   = (state == S_IDLE) || (state == S_WAIT);
    assign rd_start_en = (state == S_START);
    assign ld_active   = (state == S_START) || (state == S_WAIT);
    assign ld_done     = (state == S_DONE);
    assign ld_err      = (state == S_ERR);

    // Table reads above see the pre-write value on a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ASSET_NUM; i++) begin
                tbl_base[i] <= 32'd0;
                tbl_len[i]  <= '0;
            end
        end else if (cfg_we && cfg_ok) begin
            tbl_base[cfg_idx] <= cfg_base;
            tbl_len[cfg_idx]  <= cfg_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_d0 <= 1'b0;
            busy_d1 <= 1'b0;
        end else begin
            busy_d0 <= rd_busy;
            busy_d1 <= busy_d0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ld_id       <= '0;
            len_q       <= '0;
            ld_sec_idx  <= '0;
            rd_sec_addr <= 32'd0;
            tmo         <= '0;
            retry       <= '0;
        end else if (accept) begin
            // Acceptance in WAIT drops the sector in flight.
            ld_id       <= req_id;
            len_q       <= sel_len;
            ld_sec_idx  <= '0;
            rd_sec_addr <= sel_base;
            tmo         <= '0;
            retry       <= '0;
            state       <= empty_ld ? S_DONE : S_START;
        end else begin
            case (state)
                S_START: begin
                    tmo   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cpl) begin
                        if (ld_sec_idx == len_q - LEN_W'(1)) begin
                            state <= S_DONE;
                        end else begin
                            ld_sec_idx  <= ld_sec_idx + LEN_W'(1);
                            rd_sec_addr <= rd_sec_addr + 32'd1;
                            retry       <= '0;
                            state       <= S_START;
                        end
                    end else if (tmo == '1) begin
                        if (retry < RTY_MAX) begin
                            retry <= retry + RTY_W'(1);
                            state <= S_START;
                        end else begin
                            state <= S_ERR;
                        end
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
